stereo_image_loader: RTL

- Upstream stage of the stereo disparity engine.
- Accepts a byte stream of 8-bit grayscale pixels (UART receiver or camera adapter): one left image followed by one right image, each row-major.
- Packs every 6 consecutive pixels into one 48-bit word and writes it to the left or right frame BRAM (write port, depth 320*40, width 48).
- After the last right word is written, pulses frames_ready_out, which drives the disparity engine's new-frame trigger.

---
 rtl/stereo_pkg.sv | 23 ++
 rtl/pixel_word_packer.sv | 39 +++
 rtl/stereo_image_loader.sv | 90 +++++++++
 3 files changed

// File: rtl/stereo_pkg.sv
// Shared constants and types for the stereo disparity front end.
// Image geometry defaults describe one 240x320 grayscale frame stored as 48-bit BRAM words.
package stereo_pkg;

    localparam int BLOCK_SIZE    = 6;
    localparam int PIX_PER_WORD  = BLOCK_SIZE;
    localparam int PIX_WIDTH     = 8;
    localparam int WORD_WIDTH    = PIX_WIDTH * PIX_PER_WORD;
    localparam int IMG_WIDTH     = 240;
    localparam int IMG_HEIGHT    = 320;
    localparam int WORDS_PER_ROW = IMG_WIDTH / PIX_PER_WORD;
    localparam int IMG_WORDS     = IMG_HEIGHT * WORDS_PER_ROW;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_LEFT,
        LOAD_RIGHT,
        DONE
    } loader_state_t;

    typedef logic [WORD_WIDTH-1:0] pix_word_t;

endpackage

// File: rtl/pixel_word_packer.sv
// Gathers PIX_PER_WORD accepted pixels into one word, first pixel in the top byte.
// clear restarts the word; a pixel accepted with clear becomes pixel 0 of the new word.
module pixel_word_packer
    import stereo_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 accept,
    input  logic [PIX_WIDTH-1:0] pixel,
    output logic                 word_valid,
    output pix_word_t            word
);

    localparam int CNT_W   = $clog2(PIX_PER_WORD);
    localparam int SHREG_W = WORD_WIDTH - PIX_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIX_PER_WORD - 1);

    logic [CNT_W-1:0]   pix_cnt;
    logic [SHREG_W-1:0] shreg;

    // The final pixel is taken straight from the input so the word is ready on its acceptance cycle.
    assign word_valid = accept && !clear && (pix_cnt == LAST_CNT);
    assign word       = {shreg, pixel};

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt <= '0;
            shreg   <= '0;
        end else if (clear) begin
            pix_cnt <= accept ? CNT_W'(1) : '0;
            shreg   <= accept ? SHREG_W'(pixel) : '0;
        end else if (accept) begin
            pix_cnt <= (pix_cnt == LAST_CNT) ? '0 : pix_cnt + CNT_W'(1);
            shreg   <= {shreg[SHREG_W-PIX_WIDTH-1:0], pixel};
        end
    end

endmodule

// File: rtl/stereo_image_loader.sv
// Loads a left then a right image from a pixel byte stream into two frame BRAMs,
// then pulses frames_ready_out to trigger the disparity engine.
module stereo_image_loader
    import stereo_pkg::*;
#(
    parameter  int IMG_W       = IMG_WIDTH,
    parameter  int IMG_H       = IMG_HEIGHT,
    localparam int FRAME_WORDS = IMG_H * (IMG_W / PIX_PER_WORD),
    localparam int ADDR_W      = $clog2(FRAME_WORDS)
)(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [PIX_WIDTH-1:0]  pixel_in,
    input  logic                  pixel_valid_in,
    output logic [ADDR_W-1:0]     bram_addr_out,
    output logic [WORD_WIDTH-1:0] bram_din_out,
    output logic                  left_we_out,
    output logic                  right_we_out,
    output logic                  busy_out,
    output logic                  frames_ready_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    loader_state_t     state;
    logic              loading;
    logic              accept;
    logic              word_valid;
    logic              last_addr;
    pix_word_t         word;
    logic [ADDR_W-1:0] word_addr;

    assign loading   = (state == LOAD_LEFT) || (state == LOAD_RIGHT);
    assign busy_out  = loading;
    assign accept    = pixel_valid_in && (start_in || loading);
    assign last_addr = (word_addr == LAST_ADDR);

    pixel_word_packer u_packer (
        .clk        (clk_in),
        .rst        (rst_in),
        .clear      (start_in),
        .accept     (accept),
        .pixel      (pixel_in),
        .word_valid (word_valid),
        .word       (word)
    );

    // Row-major layout keeps addresses contiguous, so a wrapping counter replaces y*WORDS_PER_ROW+x.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            word_addr        <= '0;
            frames_ready_out <= 1'b0;
        end else begin
            frames_ready_out <= (state == DONE);
            if (start_in) begin
                state     <= LOAD_LEFT;
                word_addr <= '0;
            end else begin
                if (word_valid)
                    word_addr <= last_addr ? '0 : word_addr + ADDR_W'(1);
                case (state)
                    LOAD_LEFT:  if (word_valid && last_addr) state <= LOAD_RIGHT;
                    LOAD_RIGHT: if (word_valid && last_addr) state <= DONE;
                    DONE:       state <= IDLE;
                    default:    ;
                endcase
            end
        end
    end

    // Write stage: one-cycle we, din/addr hold between writes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            left_we_out   <= 1'b0;
            right_we_out  <= 1'b0;
            bram_din_out  <= '0;
            bram_addr_out <= '0;
        end else begin
            left_we_out  <= word_valid && (state == LOAD_LEFT);
            right_we_out <= word_valid && (state == LOAD_RIGHT);
            if (word_valid) begin
                bram_din_out  <= word;
                bram_addr_out <= word_addr;
            end
        end
    end

endmodule
